prim_rr_onehot_mux: RTL and testbench

// Registered, arbitrated N:1 data mux. Round-robin arbiter produces a one-hot grant over Inputs

---
 rtl/prim_rr_onehot_mux_pkg.sv | 15 +
 rtl/prim_and2.sv | 18 +
 rtl/prim_rr_pick.sv | 54 +++++
 rtl/prim_rr_onehot_mux.sv | 117 +++++++++++
 tb/tb_prim_rr_onehot_mux.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/prim_rr_onehot_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prim_rr_onehot_mux_pkg
// Brief    : Shared sizing helper for the round-robin one-hot mux slice.
// Revision : 1.0
// ============================================================================
package prim_rr_onehot_mux_pkg;

    // Index width that stays legal (>=1 bit) for a single channel.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prim_and2.sv
`default_nettype none
// ============================================================================
// Module   : prim_and2
// Brief    : Bitwise two-input AND primitive.
// Revision : 1.0
// ============================================================================
module prim_and2 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    output logic [WIDTH-1:0] out_o
);

    assign out_o = in0_i & in1_i;

endmodule
`default_nettype wire

// File: rtl/prim_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : prim_rr_pick
// Brief    : Combinational round-robin pick; one-hot grant starting at ptr_i.
// Revision : 1.0
// ============================================================================
module prim_rr_pick
    import prim_rr_onehot_mux_pkg::*;
#(
    parameter  int INPUTS  = 8,
    localparam int c_IDX_W = idx_width(INPUTS)
) (
    input  logic [INPUTS-1:0]  req_i,
    input  logic [c_IDX_W-1:0] ptr_i,
    input  logic               en_i,
    output logic [INPUTS-1:0]  gnt_o,
    output logic [c_IDX_W-1:0] gnt_idx_o
);

    logic [INPUTS-1:0]  w_mask;
    logic [INPUTS-1:0]  w_req_hi;
    logic [INPUTS-1:0]  w_sel;
    logic [INPUTS-1:0]  w_gnt;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_found;

    // Requests at or above the pointer win; otherwise wrap to the lowest request.
    always_comb begin
        w_mask  = '0;
        w_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < INPUTS; i++) begin
            w_mask[i] = (i >= int'(ptr_i));
        end
        w_req_hi = req_i & w_mask;
        w_sel    = (|w_req_hi) ? w_req_hi : req_i;
        for (int i = 0; i < INPUTS; i++) begin
            if (w_sel[i] && !w_found) begin
                w_gnt[i] = 1'b1;
                w_idx    = c_IDX_W'(i);
                w_found  = 1'b1;
            end
        end
        if (!en_i) begin
            w_gnt = '0;
        end
    end

    assign gnt_o     = w_gnt;
    assign gnt_idx_o = w_idx;

endmodule
`default_nettype wire

// File: rtl/prim_rr_onehot_mux.sv
`default_nettype none
// ============================================================================
// Module   : prim_rr_onehot_mux
// Brief    : Registered round-robin N:1 mux with AND/OR one-hot data select.
// Revision : 1.0
// ============================================================================
module prim_rr_onehot_mux
    import prim_rr_onehot_mux_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int INPUTS  = 8,
    localparam int c_IDX_W = idx_width(INPUTS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [INPUTS-1:0]  req_i,
    input  logic [WIDTH-1:0]   data_i [INPUTS],
    output logic [INPUTS-1:0]  gnt_o,
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_o,
    output logic [c_IDX_W-1:0] idx_o,
    input  logic               ready_i
);

    logic [c_IDX_W-1:0] r_ptr;
    logic               r_valid;
    logic [WIDTH-1:0]   r_data;
    logic [c_IDX_W-1:0] r_idx;

    logic               w_accept;
    logic [INPUTS-1:0]  w_gnt;
    logic [c_IDX_W-1:0] w_gnt_idx;
    logic [WIDTH-1:0]   w_and [INPUTS];
    logic [WIDTH-1:0]   w_next_data;

    // Grants are suppressed during reset so no requester sees a transfer that reset discards.
    assign w_accept = ~r_valid | ready_i;

    prim_rr_pick #(
        .INPUTS (INPUTS)
    ) u_pick (
        .req_i     (req_i),
        .ptr_i     (r_ptr),
        .en_i      (w_accept & rst_ni),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx)
    );

    for (genvar i = 0; i < INPUTS; i++) begin : g_chan
        prim_and2 #(
            .WIDTH (WIDTH)
        ) u_and (
            .in0_i (data_i[i]),
            .in1_i ({WIDTH{w_gnt[i]}}),
            .out_o (w_and[i])
        );
    end

    always_comb begin
        w_next_data = '0;
        for (int i = 0; i < INPUTS; i++) begin
            w_next_data = w_next_data | w_and[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
        end else if (w_accept) begin
            if (|w_gnt) begin
                r_valid <= 1'b1;
                r_data  <= w_next_data;
                r_idx   <= w_gnt_idx;
                r_ptr   <= (w_gnt_idx == c_IDX_W'(INPUTS - 1)) ? '0
                                                                : w_gnt_idx + c_IDX_W'(1);
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign gnt_o   = w_gnt;
    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign idx_o   = r_idx;

`ifndef SYNTHESIS
    logic               r_chk_hold;
    logic [WIDTH-1:0]   r_chk_data;
    logic [c_IDX_W-1:0] r_chk_idx;

    always_ff @(posedge clk_i) begin
        r_chk_hold <= rst_ni & r_valid & ~ready_i;
        r_chk_data <= r_data;
        r_chk_idx  <= r_idx;
        if (rst_ni) begin
            assert ($onehot0(w_gnt))
                else $error("prim_rr_onehot_mux: grant not onehot0 (%b)", w_gnt);
            assert ((w_gnt & ~req_i) == '0)
                else $error("prim_rr_onehot_mux: grant without request (%b/%b)", w_gnt, req_i);
            if (r_chk_hold) begin
                assert ((r_data == r_chk_data) && (r_idx == r_chk_idx))
                    else $error("prim_rr_onehot_mux: output changed while stalled");
            end
            if (r_valid) begin
                assert (int'(r_idx) < INPUTS)
                    else $error("prim_rr_onehot_mux: idx out of range (%0d)", r_idx);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_prim_rr_onehot_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_prim_rr_onehot_mux
// Brief    : Directed self-checking bench, WIDTH=8, INPUTS=4.
// Revision : 1.0
// ============================================================================
module tb_prim_rr_onehot_mux;

    localparam int c_W = 8;
    localparam int c_N = 4;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic [c_N-1:0] req_i;
    logic [c_W-1:0] data_i [c_N];
    logic [c_N-1:0] gnt_o;
    logic           valid_o;
    logic [c_W-1:0] data_o;
    logic [1:0]     idx_o;
    logic           ready_i;

    int n_checks = 0;
    int n_errors = 0;

    prim_rr_onehot_mux #(
        .WIDTH  (c_W),
        .INPUTS (c_N)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .data_i  (data_i),
        .gnt_o   (gnt_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .idx_o   (idx_o),
        .ready_i (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
            else begin
                n_errors++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] k);
        chk({tag, "_valid"}, 32'(valid_o), 32'(v));
        chk({tag, "_data"},  32'(data_o),  32'(d));
        chk({tag, "_idx"},   32'(idx_o),   32'(k));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rot_data [4];
        rot_data[0] = 8'h00; rot_data[1] = 8'h11; rot_data[2] = 8'h22; rot_data[3] = 8'h33;

        // Reset with all channels requesting
        rst_ni  = 1'b0;
        req_i   = 4'hF;
        ready_i = 1'b1;
        for (int i = 0; i < c_N; i++) data_i[i] = rot_data[i];
        tick();
        tick();
        chk_out("reset", 1'b0, 8'h00, 2'd0);
        chk("reset_gnt", 32'(gnt_o), 32'h0);

        // Release: first grant to ch0, then rotate 0..3 twice
        rst_ni = 1'b1;
        #1;
        chk("release_gnt", 32'(gnt_o), 32'h1);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk_out("rot", 1'b1, rot_data[c % 4], 2'(c % 4));
            chk("rot_gnt", 32'(gnt_o), 32'(1 << ((c + 1) % 4)));
        end

        // Backpressure: load ch2 word, stall 5 cycles with req=B
        data_i[2] = 8'hA5;
        req_i     = 4'b0100;
        #1;
        chk("bp_load_gnt", 32'(gnt_o), 32'h4);
        tick();
        chk_out("bp_load", 1'b1, 8'hA5, 2'd2);
        ready_i = 1'b0;
        req_i   = 4'hB;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_gnt", 32'(gnt_o), 32'h0);
            tick();
            chk_out("bp_hold", 1'b1, 8'hA5, 2'd2);
        end
        ready_i = 1'b1;
        #1;
        chk("bp_release_gnt", 32'(gnt_o), 32'h8);
        tick();
        chk_out("bp_release", 1'b1, 8'h33, 2'd3);

        // Wrap/skip: ptr 0 -> grant ch2 -> ptr 3; req ch1 wraps; then ch0
        data_i[0] = 8'h5C;
        req_i     = 4'b0100;
        tick();
        chk_out("wrap_pre", 1'b1, 8'hA5, 2'd2);
        req_i = 4'b0010;
        #1;
        chk("wrap_gnt1", 32'(gnt_o), 32'h2);
        tick();
        chk_out("wrap_ch1", 1'b1, 8'h11, 2'd1);
        req_i = 4'b0001;
        #1;
        chk("wrap_gnt0", 32'(gnt_o), 32'h1);
        tick();
        chk_out("wrap_ch0", 1'b1, 8'h5C, 2'd0);

        // Drain: no requests, consumer ready
        req_i     = 4'b0000;
        data_i[0] = 8'hEE;
        #1;
        chk("drain_gnt", 32'(gnt_o), 32'h0);
        tick();
        chk_out("drain", 1'b0, 8'h5C, 2'd0);

        // Reset mid-stall: ptr currently 1, grant ch2 then stall and reset
        req_i = 4'b0100;
        tick();
        chk_out("mid_load", 1'b1, 8'hA5, 2'd2);
        req_i   = 4'b0000;
        ready_i = 1'b0;
        tick();
        chk_out("mid_stall", 1'b1, 8'hA5, 2'd2);
        rst_ni = 1'b0;
        req_i  = 4'hF;
        #1;
        chk("mid_rst_gnt", 32'(gnt_o), 32'h0);
        tick();
        chk_out("mid_rst", 1'b0, 8'h00, 2'd0);
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        #1;
        chk("post_rst_gnt", 32'(gnt_o), 32'h1);
        tick();
        chk_out("post_rst", 1'b1, 8'hEE, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
